// File: rtl/stack_cpu_core.sv
// Stack-machine CPU core: unified program/data memory, LIFO with TOS/NOS, FETCH/EXEC sequencing.
// Optional multiplier for opcode 8 enabled by defining STACK_CPU_MUL_EN.
module stack_cpu_core #(
  parameter  int unsigned DW     = 8,
  parameter  int unsigned AW     = 8,
  parameter  int unsigned SDEPTH = 16,
  localparam int unsigned IW     = 4 + AW,
  localparam int unsigned SW     = $clog2(SDEPTH + 1)
) (
  input  logic          Clock,
  input  logic          reset,
  input  logic          run,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic [DW-1:0] top,
  output logic [SW-1:0] depth,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int unsigned PW    = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
  localparam int unsigned MD    = 1 << AW;

  localparam logic [3:0] OP_PUSHC = 4'h0;
  localparam logic [3:0] OP_PUSHM = 4'h1;
  localparam logic [3:0] OP_POPM  = 4'h2;
  localparam logic [3:0] OP_JMP   = 4'h3;
  localparam logic [3:0] OP_JZ    = 4'h4;
  localparam logic [3:0] OP_JN    = 4'h5;
  localparam logic [3:0] OP_ADD   = 4'h6;
  localparam logic [3:0] OP_SUB   = 4'h7;
  localparam logic [3:0] OP_MUL   = 4'h8;
  localparam logic [3:0] OP_DUP   = 4'h9;
  localparam logic [3:0] OP_SWAP  = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_ERROR} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [DW-1:0]   stk_q [SDEPTH];
  logic [DW-1:0]   stk_d [SDEPTH];
  logic [SW-1:0]   depth_q, depth_d;
  logic            z_q, z_d, n_q, n_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [1:0]      err_code_q, err_code_d;

  logic [IW-1:0]   mem_q [MD];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [IW-1:0]   mem_wdata;

  logic [3:0]      op;
  logic [AW-1:0]   k;
  logic            k_io;
  logic [PW-1:0]   tos_idx, nos_idx, push_idx;
  logic [DW-1:0]   tos, nos, alu, pushm_val;
  logic [IW-1:0]   mem_rd;
  logic [1:0]      need;
  logic            pushes, illegal;
  logic [1:0]      exec_err;

  assign op        = ir_q[IW-1:AW];
  assign k         = ir_q[AW-1:0];
  assign k_io      = (k == {AW{1'b1}});
  assign tos_idx   = PW'(depth_q - SW'(1));
  assign nos_idx   = PW'(depth_q - SW'(2));
  assign push_idx  = PW'(depth_q);
  assign tos       = stk_q[tos_idx];
  assign nos       = stk_q[nos_idx];
  assign mem_rd    = mem_q[k];
  assign pushm_val = k_io ? in_data : DW'(mem_rd);

  // Stack requirements per opcode; drives the pre-execution error check
  always_comb begin
    need    = 2'd0;
    pushes  = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_PUSHC, OP_PUSHM:       pushes = 1'b1;
      OP_POPM:                  need = 2'd1;
      OP_ADD, OP_SUB, OP_SWAP:  need = 2'd2;
`ifdef STACK_CPU_MUL_EN
      OP_MUL:                   need = 2'd2;
`else
      OP_MUL:                   illegal = 1'b1;
`endif
      OP_DUP: begin
        need   = 2'd1;
        pushes = 1'b1;
      end
      OP_JMP, OP_JZ, OP_JN, OP_HALT: ;
      default:                  illegal = 1'b1;
    endcase
  end

  always_comb begin
    exec_err = 2'd0;
    if (illegal)                                       exec_err = 2'd3;
    else if (depth_q < SW'(need))                      exec_err = 2'd2;
    else if (pushes && (depth_q == SW'(SDEPTH)))       exec_err = 2'd1;
  end

  always_comb begin
    alu = nos + tos;
    case (op)
      OP_SUB:  alu = nos - tos;
`ifdef STACK_CPU_MUL_EN
      OP_MUL:  alu = nos * tos;
`endif
      default: alu = nos + tos;
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    stk_d       = stk_q;
    depth_d     = depth_q;
    z_d         = z_q;
    n_d         = n_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_code_d  = err_code_q;
    mem_we      = 1'b0;
    mem_waddr   = prog_addr;
    mem_wdata   = prog_data;
    case (state_q)
      S_IDLE: begin
        mem_we = prog_we;
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = mem_q[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (exec_err != 2'd0) begin
          state_d    = S_ERROR;
          err_code_d = exec_err;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_q + AW'(1);
          case (op)
            OP_PUSHC: begin
              stk_d[push_idx] = DW'(k);
              depth_d         = depth_q + SW'(1);
            end
            OP_PUSHM: begin
              stk_d[push_idx] = pushm_val;
              depth_d         = depth_q + SW'(1);
            end
            OP_POPM: begin
              depth_d = depth_q - SW'(1);
              if (k_io) begin
                out_data_d  = tos;
                out_valid_d = 1'b1;
              end else begin
                mem_we    = 1'b1;
                mem_waddr = k;
                mem_wdata = IW'(tos);
              end
            end
            OP_JMP: pc_d = k;
            OP_JZ:  if (z_q) pc_d = k;
            OP_JN:  if (n_q) pc_d = k;
            OP_ADD, OP_SUB, OP_MUL: begin
              stk_d[nos_idx] = alu;
              depth_d        = depth_q - SW'(1);
              z_d            = (alu == '0);
              n_d            = alu[DW-1];
            end
            OP_DUP: begin
              stk_d[push_idx] = tos;
              depth_d         = depth_q + SW'(1);
            end
            OP_SWAP: begin
              stk_d[tos_idx] = nos;
              stk_d[nos_idx] = tos;
            end
            OP_HALT: begin
              pc_d    = pc_q;
              state_d = S_HALT;
            end
            default: ;
          endcase
        end
      end
      S_HALT: begin
        if (!run) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      end
      S_ERROR: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      for (int i = 0; i < SDEPTH; i++) stk_q[i] <= '0;
      depth_q     <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      stk_q       <= stk_d;
      depth_q     <= depth_d;
      z_q         <= z_d;
      n_q         <= n_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  // Program/data memory survives reset
  always_ff @(posedge Clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign top       = (depth_q == '0) ? '0 : tos;
  assign depth     = depth_q;
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);
  assign err       = (state_q == S_ERROR);
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_stack_cpu_core.sv
// Directed bench for stack_cpu_core (SDEPTH=4); output port values tracked through a scoreboard queue.
// Opcode 8 expectations follow STACK_CPU_MUL_EN.
module tb_stack_cpu_core;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned SDEPTH = 4;
  localparam int unsigned IW = 4 + AW;
  localparam int unsigned SW = $clog2(SDEPTH + 1);

  logic          Clock;
  logic          reset;
  logic          run;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [DW-1:0] top;
  logic [SW-1:0] depth;
  logic [AW-1:0] pc;
  logic          halted;
  logic          err;
  logic [1:0]    err_code;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q [$];

  stack_cpu_core #(.DW(DW), .AW(AW), .SDEPTH(SDEPTH)) dut (
    .Clock(Clock), .reset(reset), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .top(top), .depth(depth),
    .pc(pc), .halted(halted), .err(err), .err_code(err_code)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    prog_we = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic ld(input logic [AW-1:0] a, input logic [3:0] op, input logic [AW-1:0] k);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = {op, k};
    tick();
    prog_we = 1'b0;
  endtask

  task automatic sb_pop();
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_out", 32'(out_valid), 32'(0));
    end else begin
      e = exp_q.pop_front();
      chk("sb_out_data", 32'(out_data), 32'(e));
    end
  endtask

  task automatic run_to_stop(input int bound);
    bit stopped;
    stopped = 1'b0;
    run = 1'b1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (out_valid) sb_pop();
      if (halted || err) begin
        stopped = 1'b1;
        break;
      end
    end
    chk("stop_timeout", 32'(stopped), 32'(1));
  endtask

  initial begin
    reset = 1'b0;
    run = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    in_data = 8'd5;
    #3;
    do_reset();

    // Reset state
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_depth", 32'(depth), 32'(0));
    chk("rst_top", 32'(top), 32'(0));
    chk("rst_flags", {28'(0), halted, err, err_code}, 32'(0));
    chk("rst_out", {23'(0), out_valid, out_data}, 32'(0));

    // Add with I/O read, I/O write, exact cycle timing
    ld(0, 4'h0, 8'd23);
    ld(1, 4'h1, 8'hFF);
    ld(2, 4'h6, 8'h00);
    ld(3, 4'h2, 8'hFF);
    ld(4, 4'hF, 8'h00);
    exp_q.push_back(8'd28);
    run = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      chk($sformatf("t1_out_valid_e%0d", e), 32'(out_valid), 32'(e == 8));
      if (out_valid) sb_pop();
      if (e >= 9) chk($sformatf("t1_halted_e%0d", e), 32'(halted), 32'(e == 10));
    end
    chk("t1_depth", 32'(depth), 32'(0));
    chk("t1_sb_empty", 32'(exp_q.size()), 32'(0));
    run = 1'b0;
    tick();
    chk("t1_idle_pc", {31'(pc), halted}, 32'(0));

    // Subtract to negative, JN taken
    do_reset();
    ld(0, 4'h0, 8'd12);
    ld(1, 4'h0, 8'd20);
    ld(2, 4'h7, 8'h00);
    ld(3, 4'h5, 8'd6);
    ld(4, 4'hF, 8'h00);
    ld(5, 4'hF, 8'h00);
    ld(6, 4'hF, 8'h00);
    run_to_stop(40);
    chk("t2_top", 32'(top), 32'hF8);
    chk("t2_pc", 32'(pc), 32'd6);
    chk("t2_halted", {30'(0), halted, err}, 32'b10);

    // Overflow at SDEPTH
    do_reset();
    for (int i = 0; i < 5; i++) ld(AW'(i), 4'h0, 8'd1);
    ld(5, 4'hF, 8'h00);
    run_to_stop(40);
    chk("t3_err", {29'(0), err, err_code}, {29'(0), 1'b1, 2'd1});
    chk("t3_depth", 32'(depth), 32'd4);
    chk("t3_pc", 32'(pc), 32'd4);
    chk("t3_top", 32'(top), 32'd1);

    // Underflow; ERROR ignores run and prog_we
    do_reset();
    ld(0, 4'h0, 8'd3);
    ld(1, 4'h6, 8'h00);
    run_to_stop(40);
    chk("t4_err", {29'(0), err, err_code}, {29'(0), 1'b1, 2'd2});
    chk("t4_depth_top", {24'(depth), top}, {24'(1), 8'd3});
    chk("t4_pc", 32'(pc), 32'd1);
    run = 1'b0;
    ld(0, 4'h0, 8'd9);
    tick();
    run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_sticky", {29'(0), err, err_code}, {29'(0), 1'b1, 2'd2});
    chk("t4_sticky_pc_depth", {24'(pc), 8'(depth)}, {24'(1), 8'd1});
    do_reset();
    run_to_stop(40);
    chk("t4_mem_kept_top", 32'(top), 32'd3);
    chk("t4_mem_kept_code", 32'(err_code), 32'd2);

    // Opcode 8
    do_reset();
    ld(0, 4'h0, 8'd6);
    ld(1, 4'h0, 8'd7);
    ld(2, 4'h8, 8'h00);
    ld(3, 4'h4, 8'd9);
    ld(4, 4'h5, 8'd9);
    ld(5, 4'hF, 8'h00);
    ld(9, 4'hF, 8'h00);
    run_to_stop(40);
`ifdef STACK_CPU_MUL_EN
    chk("t5_halted", {30'(0), halted, err}, 32'b10);
    chk("t5_top", 32'(top), 32'd42);
    chk("t5_pc_flags", 32'(pc), 32'd5);
    chk("t5_depth", 32'(depth), 32'd1);
`else
    chk("t5_err", {29'(0), err, err_code}, {29'(0), 1'b1, 2'd3});
    chk("t5_depth", 32'(depth), 32'd2);
    chk("t5_pc", 32'(pc), 32'd2);
    chk("t5_top", 32'(top), 32'd7);
`endif

    // Reset during ADD EXEC, then rerun without reload
    do_reset();
    ld(0, 4'h0, 8'd23);
    ld(1, 4'h1, 8'hFF);
    ld(2, 4'h6, 8'h00);
    ld(3, 4'h2, 8'hFF);
    ld(4, 4'hF, 8'h00);
    run = 1'b1;
    for (int e = 0; e <= 5; e++) tick();
    chk("t6_pre_depth", 32'(depth), 32'd2);
    reset = 1'b1;
    run = 1'b0;
    #1;
    chk("t6_rst_depth_pc", {24'(depth), pc}, 32'(0));
    chk("t6_rst_top", 32'(top), 32'(0));
    #1;
    reset = 1'b0;
    tick();
    exp_q.push_back(8'd28);
    run_to_stop(40);
    chk("t6_halted", {30'(0), halted, err}, 32'b10);
    chk("t6_depth", 32'(depth), 32'd0);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'(0));

    // DUP/SUB zero, JZ, SWAP, memory store/load, JMP
    do_reset();
    ld(0, 4'h0, 8'd5);
    ld(1, 4'h9, 8'h00);
    ld(2, 4'h7, 8'h00);
    ld(3, 4'h4, 8'd5);
    ld(4, 4'hF, 8'h00);
    ld(5, 4'h0, 8'd9);
    ld(6, 4'h0, 8'd2);
    ld(7, 4'hA, 8'h00);
    ld(8, 4'h7, 8'h00);
    ld(9, 4'h2, 8'h80);
    ld(10, 4'h1, 8'h80);
    ld(11, 4'h2, 8'hFF);
    ld(12, 4'h3, 8'd14);
    ld(13, 4'hF, 8'h00);
    ld(14, 4'hF, 8'h00);
    exp_q.push_back(8'hF9);
    run_to_stop(80);
    chk("t7_pc", 32'(pc), 32'd14);
    chk("t7_depth_top", {24'(depth), top}, {24'(1), 8'd0});
    chk("t7_no_err", 32'(err), 32'(0));
    chk("t7_sb_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
